// File: rtl/ifb_if.sv
// Fetch-buffer bus bundle: IFU AR snoop, memory R channel, WBU flush and BDU output.
// slave = the fetch buffer's view, master = the surrounding IFU/memory/BDU view.
interface ifb_if;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_i;
  logic        ar_allow_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rready_o;
  logic        flush_i;
  logic        bdu_valid_o;
  logic        bdu_ready_i;
  logic [96:0] bdu_bus_o;

  modport slave (
    input  araddr_i, arvalid_i, arready_i, rvalid_i, rdata_i, rresp_i,
    input  flush_i, bdu_ready_i,
    output ar_allow_o, rready_o, bdu_valid_o, bdu_bus_o
  );

  modport master (
    output araddr_i, arvalid_i, arready_i, rvalid_i, rdata_i, rresp_i,
    output flush_i, bdu_ready_i,
    input  ar_allow_o, rready_o, bdu_valid_o, bdu_bus_o
  );
endinterface

// File: rtl/ifb.sv
// Instruction fetch buffer: pairs in-order R responses with snooped AR pcs and queues them for the BDU.
// Optional IFB_FAULT_CHECK_EN flags non-OKAY responses and misaligned pcs in the fault bit.
module ifb #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input logic  clock,
  input logic  reset,
  ifb_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [31:0] aq_pc_q  [DEPTH];
  logic [96:0] oq_ent_q [DEPTH];

  ptr_t aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  ptr_t oq_rd_q, oq_rd_d, oq_wr_q, oq_wr_d;
  cnt_t aq_cnt_q, aq_cnt_d, oq_cnt_q, oq_cnt_d, drop_cnt_q, drop_cnt_d;

  logic [CNT_W:0] occ;
  logic        ar_fire, r_fire, drop_hit, aq_pop, oq_push, oq_pop;
  logic        rready, ar_allow, bdu_valid, fault;
  logic [31:0] head_pc;

  assign drop_hit = (drop_cnt_q != '0);
  assign rready   = drop_hit | (aq_cnt_q != '0);
  assign occ      = {1'b0, aq_cnt_q} + {1'b0, oq_cnt_q} + {1'b0, drop_cnt_q};
  assign ar_allow = (occ < (CNT_W+1)'(DEPTH));

  assign ar_fire   = bus.arvalid_i & bus.arready_i;
  assign r_fire    = bus.rvalid_i & rready;
  assign aq_pop    = r_fire & ~drop_hit;
  assign oq_push   = aq_pop & ~bus.flush_i;
  assign bdu_valid = (oq_cnt_q != '0) & ~bus.flush_i;
  assign oq_pop    = bdu_valid & bus.bdu_ready_i;
  assign head_pc   = aq_pc_q[aq_rd_q];

`ifdef IFB_FAULT_CHECK_EN
  assign fault = (bus.rresp_i != 2'b00) | (head_pc[1:0] != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^bus.rresp_i;
  assign fault        = 1'b0;
`endif

  always_comb begin
    aq_wr_d  = aq_wr_q + PTR_W'(ar_fire);
    oq_wr_d  = oq_wr_q + PTR_W'(oq_push);
    oq_rd_d  = oq_rd_q + PTR_W'(oq_pop);
    oq_cnt_d = oq_cnt_q + CNT_W'(oq_push) - CNT_W'(oq_pop);
    if (bus.flush_i) begin
      // Emptying by pointer catch-up keeps a flush-cycle AR push aligned with aq_wr_q.
      aq_rd_d    = aq_wr_q;
      aq_cnt_d   = CNT_W'(ar_fire);
      oq_rd_d    = oq_wr_q;
      oq_cnt_d   = '0;
      drop_cnt_d = drop_cnt_q + aq_cnt_q - CNT_W'(r_fire);
    end else begin
      aq_rd_d    = aq_rd_q + PTR_W'(aq_pop);
      aq_cnt_d   = aq_cnt_q + CNT_W'(ar_fire) - CNT_W'(aq_pop);
      drop_cnt_d = drop_cnt_q - CNT_W'(r_fire & drop_hit);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aq_rd_q    <= '0;
      aq_wr_q    <= '0;
      oq_rd_q    <= '0;
      oq_wr_q    <= '0;
      aq_cnt_q   <= '0;
      oq_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      aq_rd_q    <= aq_rd_d;
      aq_wr_q    <= aq_wr_d;
      oq_rd_q    <= oq_rd_d;
      oq_wr_q    <= oq_wr_d;
      aq_cnt_q   <= aq_cnt_d;
      oq_cnt_q   <= oq_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clock) begin
    if (ar_fire) aq_pc_q[aq_wr_q] <= bus.araddr_i;
    if (oq_push) oq_ent_q[oq_wr_q] <= {fault, head_pc, head_pc + 32'h4, bus.rdata_i};
  end

  assign bus.ar_allow_o  = ar_allow;
  assign bus.rready_o    = rready;
  assign bus.bdu_valid_o = bdu_valid;
  assign bus.bdu_bus_o   = bdu_valid ? oq_ent_q[oq_rd_q] : '0;

  ap_r_proto: assert property (@(posedge clock) disable iff (!reset) bus.rvalid_i |-> rready);
  ap_ar_allow: assert property (@(posedge clock) disable iff (!reset) ar_fire |-> ar_allow);
endmodule

// File: doc/ifb.md
# ifb

Instruction fetch buffer. Sits directly downstream of the IFU: it watches the IFU's AXI-lite AR handshake, consumes the matching R-channel responses, and pairs each instruction word with its `{pc, snpc}`. It queues up to `DEPTH` fetches and presents them in order to the BDU over a valid/ready bus. A WBU redirect flushes all wrong-path fetches, including ones still in flight.

## Interface
- `DEPTH`, 2, maximum outstanding plus buffered fetches; must be a power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH)+1`, width of the occupancy counters.

- `clock`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `araddr_i`  in  32  IFU AR address, which is the fetch pc.
- `arvalid_i`  in  1  IFU AR valid.
- `arready_i`  in  1  memory AR ready.
- `ar_allow_o`  out  1  IFU may raise `arvalid`; the IFU ANDs this into its request.
- `rvalid_i`  in  1  memory R valid.
- `rdata_i`  in  32  instruction word.
- `rresp_i`  in  2  AXI response; `2'b00` is OKAY.
- `rready_o`  out  1  R ready.
- `flush_i`  in  1  WBU redirect: jump, xret or exception.
- `bdu_valid_o`  out  1  head entry valid.
- `bdu_ready_i`  in  1  BDU accepts the head entry.
- `bdu_bus_o`  out  97  `{fault, pc[31:0], snpc[31:0], inst[31:0]}`.

## Operation
- **AR fire** (`arvalid_i & arready_i`): push `{araddr_i, araddr_i+32'h4}` into the address queue (`aq`, DEPTH entries). The +4 wraps modulo 2^32.
- **R fire** (`rvalid_i & rready_o`): responses are strictly in order.
  - If `drop_cnt != 0`: decrement `drop_cnt` and discard the response.
  - Otherwise: pop the `aq` head and push `{fault, pc, snpc, rdata_i}` into the output queue (`oq`, DEPTH entries).
- `rready_o = (drop_cnt != 0) | (aq_cnt != 0)`.
  - The `oq` never overflows, because admission is bounded by the total below.
- `ar_allow_o = (aq_cnt + oq_cnt + drop_cnt) < DEPTH`.
  - Sums use `CNT_W+1` bits.
  - Counts are evaluated from registered values only. There is no same-cycle pop credit.
- **BDU pop**: on `bdu_valid_o & bdu_ready_i`, pop the `oq` head.
- **Output**: `bdu_valid_o = (oq_cnt != 0) & ~flush_i`. `bdu_bus_o` is all-zero whenever `bdu_valid_o` is 0.
- **Flush** (`flush_i`), applied at the clock edge:
  - `oq_cnt <= 0`.
  - `drop_cnt <= drop_cnt + aq_cnt - (R fire ? 1 : 0)`.
  - `aq` is cleared.
  - An AR fire in the flush cycle is kept: it is the first correct-path fetch and is pushed into the emptied `aq`.
  - An R fire in the flush cycle is discarded.
  - A BDU pop is impossible in the flush cycle, since `bdu_valid_o` is 0.
- **Simultaneous events**:
  - Push and pop on the same queue in one cycle leave its count unchanged. This holds at full and at empty+1.
  - Pointers wrap modulo DEPTH.
- **Protocol errors**:
  - `rvalid_i` while `rready_o = 0` is a protocol error. It is ignored, and an assertion fires in simulation.
  - AR fire while `ar_allow_o = 0` is an assertion failure.

## Timing
- **Reset values**: `bdu_valid_o=0`, `bdu_bus_o=0`, `rready_o=0`, `ar_allow_o=1`, all counters and pointers 0.
- Reset asserted mid-operation clears everything immediately, including `drop_cnt`. In-flight responses are the memory's concern after reset.
- **Latency**:
  - R fire in cycle N → `bdu_valid_o=1` in cycle N+1 with that entry.
  - There is no combinational path from `rdata_i` to `bdu_bus_o`.
- **Throughput**: one R fire and one BDU pop per cycle sustained.
- **Combinational paths**:
  - `ar_allow_o` and `rready_o` depend only on registers.
  - `bdu_valid_o` is combinational from `flush_i`.

## Configuration
- `IFB_FAULT_CHECK_EN` defined:
  - `fault = (rresp_i != 2'b00) | (pc[1:0] != 2'b00)`, captured at R fire.
  - A faulting entry is still delivered in order; the BDU/WBU raises the exception.
- Not defined:
  - `fault` is constant 0 and `rresp_i` is unused.
  - Misaligned pcs pass through unchecked.

## Test plan
- **Reset and single fetch**: release reset; AR fire with `araddr=32'h80000000`; R with `rdata=32'h00000413` one cycle later. Required: `bdu_valid_o=1` next cycle with bus `{0, 80000000, 80000004, 00000413}`; `ar_allow_o` returns to 1 after the pop.
- **Backpressure full**: DEPTH=2; two AR fires at `80000000` and `80000004`, both responded to, `bdu_ready_i=0`. Required: `ar_allow_o=0`, `rready_o=0`, `oq` holds both entries in order. Raise ready for 2 cycles → both pop, then `ar_allow_o=1`.
- **Flush with in-flight reads**: two ARs outstanding, no R yet; `flush_i` pulses while a new AR fires at `80000100`. Required: next two R responses are dropped (`bdu_valid_o` stays 0); the third R is delivered with `pc=80000100`.
- **Flush with buffered entries**: `oq` holds 2 entries; `flush_i` with `bdu_ready_i=1`. Required: `bdu_valid_o=0` in the flush cycle, no pop occurs, `oq_cnt=0` after.
- **Wrap**: AR at `32'hFFFFFFFC`. Required: `snpc=32'h00000000`. Additionally, 8 back-to-back fetch/pop pairs cross pointer wrap with no reordering.
- **Fault** (`IFB_FAULT_CHECK_EN`): `rresp=2'b10` at `pc 80000008` → `fault=1`; AR at `80000002` with OKAY → `fault=1`. With the macro undefined, both give `fault=0`.
